// File: rtl/i2s_pkg.sv
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants and state encoding for the I2S receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int   DEFAULT_WIDTH = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// ============================================================================
// Module      : i2s_sync_edge
// Description : Two-flop synchronizer with a registered rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_sync = r_s2;
    assign o_rise = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/i2s_receiver.sv
// ============================================================================
// Module      : i2s_receiver
// Description : I2S slave receiver recovering left/right words in clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             BCLK,
    input  logic             LRCLK,
    input  logic             SDATA,
    output logic [WIDTH-1:0] left_audio,
    output logic [WIDTH-1:0] right_audio,
    output logic             sample_valid,
    output logic             RightNLeft,
    output logic             short_slot
);

    localparam logic [CNT_W-1:0] c_width_cnt = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] c_msb       = {1'b1, {(WIDTH-1){1'b0}}};

    logic w_bclk_rise, w_bclk_sync_unused;
    logic w_lr, w_lr_rise_unused;
    logic w_sd, w_sd_rise_unused;

    i2s_sync_edge u_sync_bclk (.clk(clk), .rst(rst), .i_d(BCLK),  .o_sync(w_bclk_sync_unused), .o_rise(w_bclk_rise));
    i2s_sync_edge u_sync_lr   (.clk(clk), .rst(rst), .i_d(LRCLK), .o_sync(w_lr), .o_rise(w_lr_rise_unused));
    i2s_sync_edge u_sync_sd   (.clk(clk), .rst(rst), .i_d(SDATA), .o_sync(w_sd), .o_rise(w_sd_rise_unused));

    state_t           r_state, w_state_n;
    logic             r_primed, w_primed_n;
    logic             r_lr_prev, w_lr_prev_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n, w_cnt_inc;
    logic [WIDTH-1:0] r_word, w_word_n, w_word_upd, w_mask;
    logic [WIDTH-1:0] r_left, w_left_n;
    logic [WIDTH-1:0] r_right, w_right_n;
    logic             r_valid, w_valid_n;
    logic             r_short, w_short_n;
    logic             r_rnl, w_rnl_n;

    // Bits beyond WIDTH get an all-zero mask, which truncates long slots.
    assign w_mask     = (r_cnt < c_width_cnt) ? (c_msb >> r_cnt) : '0;
    assign w_word_upd = w_sd ? (r_word | w_mask) : r_word;
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_primed  <= 1'b0;
            r_lr_prev <= 1'b0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_short   <= 1'b0;
            r_rnl     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_primed  <= w_primed_n;
            r_lr_prev <= w_lr_prev_n;
            r_cnt     <= w_cnt_n;
            r_word    <= w_word_n;
            r_left    <= w_left_n;
            r_right   <= w_right_n;
            r_valid   <= w_valid_n;
            r_short   <= w_short_n;
            r_rnl     <= w_rnl_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_primed_n  = r_primed;
        w_lr_prev_n = r_lr_prev;
        w_cnt_n     = r_cnt;
        w_word_n    = r_word;
        w_left_n    = r_left;
        w_right_n   = r_right;
        w_valid_n   = 1'b0;
        w_short_n   = 1'b0;
        w_rnl_n     = r_rnl;
        if (!enable) begin
            w_state_n = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_n  = SEEK;
                    w_primed_n = 1'b0;
                end
                // The first edge only records LRCLK so a stale lr_prev cannot fake a boundary.
                SEEK: begin
                    if (w_bclk_rise) begin
                        w_lr_prev_n = w_lr;
                        w_primed_n  = 1'b1;
                        if (r_primed && (w_lr != r_lr_prev)) begin
                            w_state_n = RUN;
                            w_cnt_n   = '0;
                            w_word_n  = '0;
                            w_rnl_n   = w_lr;
                        end
                    end
                end
                RUN: begin
                    if (w_bclk_rise) begin
                        w_rnl_n = w_lr;
                        if (w_lr == r_lr_prev) begin
                            w_word_n = w_word_upd;
                            w_cnt_n  = w_cnt_inc;
                        end else begin
                            // One-bit delay: this bit still belongs to the old slot.
                            if (r_lr_prev == CH_LEFT) begin
                                w_left_n = w_word_upd;
                            end else begin
                                w_right_n = w_word_upd;
                                w_valid_n = 1'b1;
                            end
                            w_short_n   = (w_cnt_inc < c_width_cnt);
                            w_word_n    = '0;
                            w_cnt_n     = '0;
                            w_lr_prev_n = w_lr;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign left_audio   = r_left;
    assign right_audio  = r_right;
    assign sample_valid = r_valid;
    assign short_slot   = r_short;
    assign RightNLeft   = r_rnl;

endmodule

`default_nettype wire

// File: tb/tb_i2s_receiver.sv
// ============================================================================
// Module      : tb_i2s_receiver
// Description : Self-checking bench driving a behavioural I2S master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        BCLK = 1'b1;
    logic        LRCLK = 1'b0;
    logic        SDATA = 1'b0;
    logic [15:0] left_audio;
    logic [15:0] right_audio;
    logic        sample_valid;
    logic        RightNLeft;
    logic        short_slot;

    i2s_receiver #(.WIDTH(16), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA),
        .left_audio(left_audio), .right_audio(right_audio),
        .sample_valid(sample_valid), .RightNLeft(RightNLeft), .short_slot(short_slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        care;
        logic [15:0] l;
        logic [15:0] r;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   total  = 0;
    int   bad    = 0;
    int   shorts = 0;
    int   pulses = 0;
    logic pend    = 1'b0;
    logic chk_rnl = 1'b0;

    // Scoreboard: every sample_valid pops one expected frame.
    always @(negedge clk) begin
        if (short_slot === 1'b1) shorts++;
        if (sample_valid === 1'b1) begin
            pulses++;
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_valid: sample_valid=1 required=0 at %0t", $time);
            end else begin
                m_e = q.pop_front();
                if (m_e.care) begin
                    total++;
                    if (left_audio !== m_e.l) begin
                        bad++;
                        $display("FAIL frame_left: got=%h want=%h at %0t", left_audio, m_e.l, $time);
                    end
                    total++;
                    if (right_audio !== m_e.r) begin
                        bad++;
                        $display("FAIL frame_right: got=%h want=%h at %0t", right_audio, m_e.r, $time);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] expect_word(input logic [23:0] d, input int len);
        logic [23:0] t;
        if (len >= 16) t = d >> (len - 16);
        else           t = d << (16 - len);
        return t[15:0];
    endfunction

    // SDATA lags LRCLK by one bit period (Philips framing).
    task automatic bit_period(input logic ch, input logic b);
        BCLK  = 1'b0;
        LRCLK = ch;
        SDATA = pend;
        pend  = b;
        #40;
        BCLK  = 1'b1;
        #40;
    endtask

    task automatic send_slot(input logic ch, input logic [23:0] data, input int len);
        for (int i = 0; i < len; i++) begin
            bit_period(ch, data[len-1-i]);
            if (chk_rnl && (i == len/2)) begin
                total++;
                if (RightNLeft !== ch) begin
                    bad++;
                    $display("FAIL right_n_left: got=%b want=%b", RightNLeft, ch);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int len,
                              input logic push, input logic care);
        exp_t e;
        e.care = care;
        e.l    = expect_word(l, len);
        e.r    = expect_word(r, len);
        if (push) q.push_back(e);
        send_slot(1'b0, l, len);
        send_slot(1'b1, r, len);
    endtask

    // Open left slot lets the last right slot finalize, then receive is parked.
    task automatic close_stream(input int len);
        send_slot(1'b0, 24'h0, len);
        repeat (10) @(posedge clk);
    endtask

    task automatic park();
        enable = 1'b0;
        repeat (5) @(posedge clk);
        q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (left_audio   !== 16'h0) begin bad++; $display("FAIL reset_left: got=%h want=0000", left_audio); end
        total++; if (right_audio  !== 16'h0) begin bad++; $display("FAIL reset_right: got=%h want=0000", right_audio); end
        total++; if (sample_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid: got=%b want=0", sample_valid); end
        total++; if (short_slot   !== 1'b0)  begin bad++; $display("FAIL reset_short: got=%b want=0", short_slot); end
        total++; if (RightNLeft   !== 1'b0)  begin bad++; $display("FAIL reset_rnl: got=%b want=0", RightNLeft); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_basic();
        int s0, p0;
        s0 = shorts; p0 = pulses;
        enable  = 1'b1;
        chk_rnl = 1'b1;
        send_frame(24'hF0F0, 24'hAAAA, 16, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send_frame(24'hF0F0, 24'hAAAA, 16, 1'b1, 1'b1);
        close_stream(16);
        chk_rnl = 1'b0;
        total++; if (q.size() != 0) begin bad++; $display("FAIL basic_pending: got=%0d want=0", q.size()); end
        total++; if (pulses - p0 != 4) begin bad++; $display("FAIL basic_pulses: got=%0d want=4", pulses - p0); end
        total++; if (shorts - s0 != 0) begin bad++; $display("FAIL basic_short: got=%0d want=0", shorts - s0); end
        park();
    endtask

    task automatic test_lsb_msb();
        int s0;
        s0 = shorts;
        enable = 1'b1;
        send_frame(24'h0001, 24'h8000, 16, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) send_frame(24'h0001, 24'h8000, 16, 1'b1, 1'b1);
        close_stream(16);
        total++; if (q.size() != 0) begin bad++; $display("FAIL lsbmsb_pending: got=%0d want=0", q.size()); end
        total++; if (shorts - s0 != 0) begin bad++; $display("FAIL lsbmsb_short: got=%0d want=0", shorts - s0); end
        park();
    endtask

    task automatic test_long_slot();
        int s0;
        s0 = shorts;
        enable = 1'b1;
        send_frame(24'hABCDEF, 24'h123456, 24, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) send_frame(24'hABCDEF, 24'h123456, 24, 1'b1, 1'b1);
        close_stream(24);
        total++; if (q.size() != 0) begin bad++; $display("FAIL long_pending: got=%0d want=0", q.size()); end
        total++; if (shorts - s0 != 0) begin bad++; $display("FAIL long_short: got=%0d want=0", shorts - s0); end
        park();
    endtask

    task automatic test_short_slot();
        int s0;
        s0 = shorts;
        enable = 1'b1;
        send_frame(24'hAB, 24'hCD, 8, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send_frame(24'hAB, 24'hCD, 8, 1'b1, 1'b1);
        close_stream(8);
        total++; if (q.size() != 0) begin bad++; $display("FAIL shortslot_pending: got=%0d want=0", q.size()); end
        // locking right slot plus two per full frame
        total++; if (shorts - s0 != 7) begin bad++; $display("FAIL shortslot_count: got=%0d want=7", shorts - s0); end
        park();
    endtask

    task automatic test_enable_gap();
        enable = 1'b1;
        send_frame(24'h1234, 24'h5678, 16, 1'b1, 1'b0);
        send_frame(24'h1234, 24'h5678, 16, 1'b1, 1'b1);
        fork
            send_frame(24'h9999, 24'h7777, 16, 1'b0, 1'b0);
            begin
                #(1280 + 160);
                enable = 1'b0;
                repeat (100) @(posedge clk);
                enable = 1'b1;
            end
        join
        total++; if (right_audio !== 16'h5678) begin bad++; $display("FAIL gap_right_hold: got=%h want=5678", right_audio); end
        send_frame(24'hCAFE, 24'hBEEF, 16, 1'b1, 1'b1);
        send_frame(24'h0F0F, 24'h1E1E, 16, 1'b1, 1'b1);
        close_stream(16);
        total++; if (q.size() != 0) begin bad++; $display("FAIL gap_pending: got=%0d want=0", q.size()); end
        park();
    endtask

    task automatic test_async_reset();
        exp_t e;
        enable = 1'b1;
        send_frame(24'h1111, 24'h2222, 16, 1'b1, 1'b0);
        send_frame(24'h1111, 24'h2222, 16, 1'b1, 1'b1);
        // After re-lock only the right word of the interrupted frame is seen.
        e.care = 1'b1; e.l = 16'h0000; e.r = 16'h4444;
        q.push_back(e);
        fork
            send_frame(24'h3333, 24'h4444, 16, 1'b0, 1'b0);
            begin
                #303;
                rst = 1'b0;
                #1;
                total++; if (left_audio  !== 16'h0) begin bad++; $display("FAIL arst_left: got=%h want=0000", left_audio); end
                total++; if (right_audio !== 16'h0) begin bad++; $display("FAIL arst_right: got=%h want=0000", right_audio); end
                total++; if (RightNLeft  !== 1'b0)  begin bad++; $display("FAIL arst_rnl: got=%b want=0", RightNLeft); end
                #50;
                rst = 1'b1;
            end
        join
        send_frame(24'h5555, 24'h6666, 16, 1'b1, 1'b1);
        close_stream(16);
        total++; if (q.size() != 0) begin bad++; $display("FAIL arst_pending: got=%0d want=0", q.size()); end
        park();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lsb_msb();
        test_long_slot();
        test_short_slot();
        test_enable_gap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- I2S slave receiver; the receive-side counterpart of the team's I2S master transmitter.
- Samples externally driven BCLK/LRCLK/SDATA in the system clk domain.
- Recovers left and right audio words and presents them as parallel words with a one-cycle frame strobe.
- Intended for loopback against the master and for codec ADC input paths.

Parameters:
- WIDTH, 16, audio word width in bits (MSB-first, left-justified in slot).
- CNT_W, 6, slot bit-counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; must be >= 4x BCLK frequency.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  receive enable; low forces IDLE.
- BCLK  input  1  I2S bit clock; asynchronous to clk.
- LRCLK  input  1  word select; 0 = left, 1 = right.
- SDATA  input  1  serial data; valid at BCLK rising edge.
- left_audio  output  WIDTH  last completed left word.
- right_audio  output  WIDTH  last completed right word.
- sample_valid  output  1  one-clk pulse when a left+right frame completes.
- RightNLeft  output  1  channel of the slot currently being received.
- short_slot  output  1  one-clk pulse when a completed slot held fewer than WIDTH bits.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, shift register/counters/lr_prev cleared.
- Input conditioning:
  - BCLK, LRCLK and SDATA each pass through a 2-flop synchronizer.
  - A third BCLK flop drives rising-edge detection, bclk_rise = 1 clk.
  - LRCLK/SDATA are sampled from synchronizer outputs on bclk_rise, so they stay aligned with BCLK.
- States:
  - IDLE: enable=0. Ignore inputs; outputs hold their values; pulses 0. enable=1 -> SEEK.
  - SEEK: on each bclk_rise record lr_prev=LRCLK. The first bclk_rise where LRCLK != lr_prev -> RUN with cnt=0. No word is output for that partial slot.
  - RUN: on each bclk_rise, with lr = sampled LRCLK:
    - lr == lr_prev: if cnt < WIDTH, write SDATA into word bit WIDTH-1-cnt. cnt++ (saturating).
    - lr != lr_prev (slot boundary, Philips one-bit delay): this bit is the LSB-period bit of the old slot; store it as above if cnt < WIDTH. Finalize word for channel lr_prev; unfilled low bits are 0. If final count < WIDTH, pulse short_slot. Clear word and cnt; lr_prev <= lr.
    - RightNLeft <= lr.
  - enable=0 in any state -> IDLE next clk; a partial slot is discarded.
- Finalize rules:
  - Left slot: left_audio <= word.
  - Right slot: right_audio <= word and sample_valid=1 for exactly one clk.
  - A frame is left followed by right.
- Width and timing rules:
  - Slots longer than WIDTH are truncated to the first WIDTH bits.
  - Latency: BCLK rising edge at pin -> output register update within 4 clk.
- Simultaneous events:
  - enable falling on the same clk as a finalize: enable wins; no update, no pulse.
  - rst asserted mid-slot: immediate clear. After release the block restarts in IDLE and must re-lock via SEEK.

Decomposition:
- Package i2s_pkg:
  - Channel constants CH_LEFT=0, CH_RIGHT=1.
  - State encoding IDLE/SEEK/RUN.
  - Default WIDTH.
- Sub-module i2s_sync_edge: 2-flop synchronizer plus rise-detect output, instantiated for BCLK. LRCLK and SDATA use its sync path only, with the edge output unused.

Test Plan:
- Reset, then enable=1; behavioural master sends left=16'hF0F0, right=16'hAAAA with 16-bit slots at BCLK=clk/8 -> after the first lock, every frame gives left_audio=F0F0, right_audio=AAAA, one sample_valid per frame, short_slot never asserted.
- Left=16'h0001, right=16'h8000 -> outputs match exactly, confirming that the LSB on the LRCLK-change bit goes to the old channel and the MSB goes to the new one.
- 24-bit slots carrying 24'hABCDEF / 24'h123456 with WIDTH=16 -> left_audio=ABCD, right_audio=1234, no short_slot.
- 8-bit slots carrying 8'hAB / 8'hCD -> left_audio=AB00, right_audio=CD00, short_slot pulses twice per frame.
- enable dropped mid-right-slot for 100 clk, then raised -> no sample_valid during the gap; the first partial slot after re-enable is discarded; the next full frame is correct.
- rst asserted mid-slot (async, between clk edges) -> all outputs 0 immediately; after release, correct words appear only after re-lock.
